// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/stop and clear buttons drive an
// IDLE/RUN/PAUSE FSM and a prescaler that emits count ticks to a BCD chain.
//
// state  | meaning
// IDLE   | stopped, prescaler cleared
// RUN    | prescaler advancing, inc pulses every DIV cycles
// PAUSE  | stopped, prescaler holds its partial tick
module stopwatch_ctrl #(
  parameter int unsigned DIV       = 100000,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_clr,
  output logic       inc,
  output logic       count_clr,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned DIV_W = $clog2(DIV);
  localparam int unsigned DB_W  = $clog2(DB_CYCLES);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_e;

  // bit 0 = start/stop, bit 1 = clear
  logic [1:0]           sync1_q, sync1_d;
  logic [1:0]           sync2_q, sync2_d;
  logic [1:0]           db_q, db_d;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]           press;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 inc_q, inc_d;
  logic                 count_clr_q, count_clr_d;
  logic                 running_q, running_d;
  logic                 advance;

  always_comb begin
    sync1_d  = {btn_clr, btn_ss};
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    press    = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_MAX) begin
        db_d[i]     = sync2_q[i];
        db_cnt_d[i] = '0;
        press[i]    = sync2_q[i];  // only a 0->1 acceptance is an event
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    count_clr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press[1]) count_clr_d = 1'b1;
        else if (press[0]) state_d = S_RUN;
      end
      S_RUN: begin
        if (press[0]) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (press[1]) begin
          state_d     = S_IDLE;
          count_clr_d = 1'b1;
        end else if (press[0]) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The prescaler only advances on edges that stay in RUN, so the entry edge
  // and the pause edge leave the partial tick untouched.
  always_comb begin
    advance   = (state_q == S_RUN) && (state_d == S_RUN);
    div_cnt_d = div_cnt_q;
    inc_d     = 1'b0;
    if (state_d == S_IDLE) begin
      div_cnt_d = '0;
    end else if (advance) begin
      if (div_cnt_q == DIV_MAX) begin
        div_cnt_d = '0;
        inc_d     = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      db_cnt_q    <= '0;
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      inc_q       <= 1'b0;
      count_clr_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      inc_q       <= inc_d;
      count_clr_q <= count_clr_d;
      running_q   <= running_d;
    end
  end

  assign inc       = inc_q;
  assign count_clr = count_clr_q;
  assign running   = running_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=4, DB_CYCLES=8: a vector table
// of button presses plus hand sequences for tick timing, bounce and reset.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;
  localparam int DB  = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_ss;
  logic       btn_clr;
  logic       inc;
  logic       count_clr;
  logic       running;
  logic [1:0] state;

  stopwatch_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_ss    (btn_ss),
    .btn_clr   (btn_clr),
    .inc       (inc),
    .count_clr (count_clr),
    .running   (running),
    .state     (state)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int n_inc   = 0;
  int n_ccl   = 0;
  int mon_err = 0;
  logic prev_inc = 1'b0;
  logic prev_ccl = 1'b0;

  typedef struct {
    logic       ss;
    logic       clr;
    int         hold;
    logic [1:0] exp_state;
    int         exp_ccl;
    bit         no_inc;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Advance one cycle, sample at the falling edge and tally pulses/invariants.
  task automatic tick();
    @(negedge clock);
    if (inc) n_inc++;
    if (count_clr) n_ccl++;
    if (inc && (prev_inc || state != 2'b01 || count_clr)) mon_err++;
    if (count_clr && prev_ccl) mon_err++;
    if (state == 2'b11) mon_err++;
    if (running != (state == 2'b01)) mon_err++;
    prev_inc = inc;
    prev_ccl = count_clr;
  endtask

  initial begin
    int t_run, t_inc1, t_inc2, t_pause, held, run_cnt, i0, c0;
    bit got;

    vecs[0]  = '{1'b1, 1'b0, 12, 2'b10, 0, 1'b0};  // RUN -> PAUSE
    vecs[1]  = '{1'b0, 1'b0, 10, 2'b10, 0, 1'b1};  // PAUSE holds, no tick
    vecs[2]  = '{1'b0, 1'b1, 12, 2'b00, 1, 1'b1};  // PAUSE clr -> IDLE
    vecs[3]  = '{1'b0, 1'b1, 12, 2'b00, 1, 1'b1};  // IDLE clr, clear again
    vecs[4]  = '{1'b1, 1'b0, 12, 2'b01, 0, 1'b0};  // IDLE -> RUN
    vecs[5]  = '{1'b0, 1'b1, 12, 2'b01, 0, 1'b0};  // clr ignored in RUN
    vecs[6]  = '{1'b1, 1'b1, 12, 2'b10, 0, 1'b0};  // both in RUN -> PAUSE
    vecs[7]  = '{1'b1, 1'b0, 12, 2'b01, 0, 1'b0};  // PAUSE -> RUN
    vecs[8]  = '{1'b1, 1'b0, 12, 2'b10, 0, 1'b0};  // RUN -> PAUSE
    vecs[9]  = '{1'b1, 1'b1, 12, 2'b00, 1, 1'b1};  // both in PAUSE -> IDLE
    vecs[10] = '{1'b1, 1'b1, 12, 2'b00, 1, 1'b1};  // both in IDLE: clr wins

    reset = 1'b1; btn_ss = 1'b0; btn_clr = 1'b0;
    repeat (3) tick();
    check("rst_state", int'(state), 0);
    check("rst_running", int'(running), 0);
    check("rst_inc", int'(inc), 0);
    check("rst_count_clr", int'(count_clr), 0);
    reset = 1'b0;
    tick();

    // Start: latency and tick cadence.
    t_run = -1; t_inc1 = -1; t_inc2 = -1;
    btn_ss = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (t == 20) btn_ss = 1'b0;
      tick();
      if (t_run < 0 && state == 2'b01) t_run = t;
      if (inc && t_inc1 < 0) t_inc1 = t;
      else if (inc && t_inc2 < 0) t_inc2 = t;
    end
    check_range("start_latency", t_run + 1, DB, DB + 5);
    check("first_inc_delay", t_inc1 - t_run, DIV);
    check("inc_period", t_inc2 - t_inc1, DIV);
    check("start_running", int'(running), 1);

    for (int i = 0; i < NV; i++) begin
      i0 = n_inc; c0 = n_ccl;
      btn_ss = vecs[i].ss; btn_clr = vecs[i].clr;
      repeat (vecs[i].hold) tick();
      btn_ss = 1'b0; btn_clr = 1'b0;
      repeat (14) tick();
      check($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].exp_state));
      check($sformatf("vec%0d_count_clr", i), n_ccl - c0, vecs[i].exp_ccl);
      if (vecs[i].no_inc) check($sformatf("vec%0d_inc", i), n_inc - i0, 0);
    end

    // Pause mid-tick, then resume: the partial tick must be preserved.
    btn_ss = 1'b1; repeat (12) tick(); btn_ss = 1'b0; repeat (14) tick();
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      tick();
      got = inc;
    end
    check("pause_seq_inc_seen", int'(got), 1);
    run_cnt = 0; t_pause = -1; held = 0; i0 = 0;
    for (int t = 0; t < 30; t++) begin
      if (t == 2) btn_ss = 1'b1;
      if (t == 14) btn_ss = 1'b0;
      tick();
      if (t_pause < 0 && state == 2'b01) begin
        if (inc) run_cnt = 0;
        else run_cnt++;
      end
      if (t_pause < 0 && state == 2'b10) begin
        t_pause = t;
        held = run_cnt;
        i0 = n_inc;
      end
    end
    check("pause_reached", int'(t_pause >= 0), 1);
    check("pause_no_inc", n_inc - i0, 0);
    check("pause_state", int'(state), 2);
    t_run = -1; t_inc1 = -1;
    btn_ss = 1'b1;
    for (int t = 0; t < 30; t++) begin
      if (t == 12) btn_ss = 1'b0;
      tick();
      if (t_run < 0 && state == 2'b01) t_run = t;
      if (t_run >= 0 && t_inc1 < 0 && inc) t_inc1 = t;
    end
    check("resume_running", int'(t_run >= 0), 1);
    check("resume_inc_delay", t_inc1 - t_run, DIV - held);

    // Reset mid-RUN with the prescaler at 2.
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      tick();
      got = inc;
    end
    check("rst_run_inc_seen", int'(got), 1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("midrun_rst_state", int'(state), 0);
    check("midrun_rst_inc", int'(inc), 0);
    check("midrun_rst_count_clr", int'(count_clr), 0);
    reset = 1'b0;
    i0 = n_inc;
    repeat (20) tick();
    check("after_rst_no_inc", n_inc - i0, 0);
    check("after_rst_state", int'(state), 0);

    // Bounce shorter than the debounce window must be rejected.
    i0 = n_inc; c0 = n_ccl;
    for (int t = 0; t < 40; t++) begin
      btn_ss = ((t / 3) % 2 == 0);
      tick();
    end
    btn_ss = 1'b0;
    repeat (15) tick();
    check("bounce_state", int'(state), 0);
    check("bounce_no_inc", n_inc - i0, 0);
    check("bounce_no_clr", n_ccl - c0, 0);

    // Button held through reset release yields one press.
    btn_ss = 1'b1; reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    t_run = -1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (t_run < 0 && state == 2'b01) t_run = t;
    end
    check("held_rst_running", int'(t_run >= 0), 1);
    check_range("held_rst_latency", t_run + 1, DB, DB + 5);
    btn_ss = 1'b0;
    repeat (14) tick();
    check("held_rst_state", int'(state), 1);

    check("invariants", mon_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
